// File: rtl/arm_data_mem_responder.sv
// ---------------------------------------------------------------------------
// arm_data_mem_responder
//
// Memory-side responder for the pipelined ARM core's data port. CPU loads and
// stores are served from a small word RAM. A memory-mapped camera block sits
// at CAM_BASE and holds three registers:
//   +0  CAM_DATA   load pops the oldest pixel (zero-extended), 0 when empty
//   +4  CAM_STATUS {overflow, full, empty, 0..., count}; a store with
//                  wdata[31]=1 clears the sticky overflow flag
//   +8  FRAME_CNT  16-bit start-of-frame counter, writable by the CPU
// The camera side pushes pixels into the FIFO whenever it has room.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset      asynchronous, active-low
//   addr       CPU byte address (ALUResult); addr[1:0] ignored
//   wdata      CPU store data (WriteData)
//   we         CPU store strobe
//   re         CPU load strobe; only a load from CAM_DATA pops the FIFO
//   rdata      CPU load data, combinational from addr
//   cam_valid  pixel present this cycle
//   cam_pixel  pixel value
//   cam_sof    start-of-frame pulse
//   cam_ready  FIFO not full
// ---------------------------------------------------------------------------
module arm_data_mem_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PIX_W      = 16,
    parameter logic [31:0] CAM_BASE   = 32'h1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rdata,
    input  logic             cam_valid,
    input  logic [PIX_W-1:0] cam_pixel,
    input  logic             cam_sof,
    output logic             cam_ready
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]      ram_mem  [RAM_WORDS];
    logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      frame_cnt;

    logic [31:0]       word_addr;
    logic              sel_ram;
    logic              sel_cam_data;
    logic              sel_status;
    logic              sel_frame;
    logic [RAM_AW-1:0] ram_idx;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              ovf_clr;
    logic              frame_wr;
    logic [31:0]       status_word;

    // Address decode. The camera registers are word aligned, so the two low
    // address bits are masked before comparing against the register offsets.
    assign word_addr    = {addr[31:2], 2'b00};
    assign sel_ram      = (addr < RAM_BYTES);
    assign sel_cam_data = (word_addr == CAM_BASE);
    assign sel_status   = (word_addr == CAM_BASE + 32'd4);
    assign sel_frame    = (word_addr == CAM_BASE + 32'd8);
    assign ram_idx      = addr[RAM_AW+1:2];

    // FIFO control. Push looks only at the registered full flag, so a pop on
    // the same edge never makes room for a pixel that arrives while full.
    // A store to CAM_DATA is neither a push nor a pop.
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = cam_valid & ~full;
    assign pop      = re & ~we & sel_cam_data & ~empty;
    assign ovf_set  = cam_valid & full;
    assign ovf_clr  = we & sel_status & wdata[31];
    assign frame_wr = we & sel_frame;

    assign cam_ready = ~full;

    // Data RAM: not reset, written only while the block is out of reset.
    always_ff @(posedge clk) begin
        if (reset && we && sel_ram) begin
            ram_mem[ram_idx] <= wdata;
        end
    end

    // Pixel storage: the pointers carry the real state, so the array itself
    // needs no reset and stale entries behind rd_ptr are simply never read.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= cam_pixel;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and frame counter. A new
    // overflow on the same edge as a CPU clear wins, and a CPU store to
    // FRAME_CNT wins over a start-of-frame increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (frame_wr) begin
                frame_cnt <= wdata[15:0];
            end else if (cam_sof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Status word assembled from registered state only.
    always_comb begin
        status_word              = '0;
        status_word[31]          = overflow;
        status_word[30]          = full;
        status_word[29]          = empty;
        status_word[PTR_W:0]     = count;
    end

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        rdata = '0;
        if (sel_ram) begin
            rdata = ram_mem[ram_idx];
        end else if (sel_cam_data) begin
            if (!empty) begin
                rdata = {{(32-PIX_W){1'b0}}, fifo_mem[rd_ptr]};
            end
        end else if (sel_status) begin
            rdata = status_word;
        end else if (sel_frame) begin
            rdata = {16'h0000, frame_cnt};
        end
    end

endmodule

// File: tb/tb_arm_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_arm_data_mem_responder
//
// Self-checking bench for arm_data_mem_responder. A behavioural model keeps
// the FIFO as a queue of pixels, the RAM as an associative array of words and
// the flags/counters as plain variables; every expected read value comes from
// that model. Inputs change 1 ns after a rising edge and outputs are sampled
// 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_arm_data_mem_responder;

    localparam int          DEPTH    = 16;
    localparam int          PIX_W    = 16;
    localparam logic [31:0] CAM_BASE = 32'h1000;
    localparam logic [31:0] A_DATA   = CAM_BASE;
    localparam logic [31:0] A_STATUS = CAM_BASE + 32'd4;
    localparam logic [31:0] A_FRAME  = CAM_BASE + 32'd8;

    logic             clk;
    logic             reset;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             we;
    logic             re;
    logic [31:0]      rdata;
    logic             cam_valid;
    logic [PIX_W-1:0] cam_pixel;
    logic             cam_sof;
    logic             cam_ready;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [PIX_W-1:0] q_model[$];
    logic [31:0]      ram_model[int];
    bit               ovf_model;
    logic [15:0]      frame_model;

    arm_data_mem_responder #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(DEPTH),
        .PIX_W     (PIX_W),
        .CAM_BASE  (CAM_BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .cam_valid(cam_valid),
        .cam_pixel(cam_pixel),
        .cam_sof  (cam_sof),
        .cam_ready(cam_ready)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected load data for an address, taken from the model.
    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] w;
        int          sz;
        w  = a & 32'hFFFF_FFFC;
        sz = q_model.size();
        if (a < 32'd256) begin
            if (ram_model.exists(int'(a >> 2))) return ram_model[int'(a >> 2)];
            return 32'hxxxx_xxxx;
        end
        if (w == A_DATA)   return (sz > 0) ? {16'h0000, q_model[0]} : 32'h0;
        if (w == A_STATUS) return (ovf_model ? 32'h8000_0000 : 32'h0) |
                                  ((sz == DEPTH) ? 32'h4000_0000 : 32'h0) |
                                  ((sz == 0) ? 32'h2000_0000 : 32'h0) |
                                  32'(sz);
        if (w == A_FRAME)  return {16'h0000, frame_model};
        return 32'h0;
    endfunction

    // Advance the model by one edge using the current inputs, then wait for
    // that edge and settle 1 ns past it.
    task automatic step();
        logic [31:0] w;
        bit          was_full;
        bit          ovf_new;
        w        = addr & 32'hFFFF_FFFC;
        was_full = (q_model.size() == DEPTH);
        ovf_new  = 1'b0;
        if (reset) begin
            if (we && addr < 32'd256) ram_model[int'(addr >> 2)] = wdata;
            if (re && !we && w == A_DATA && q_model.size() > 0) void'(q_model.pop_front());
            if (cam_valid) begin
                if (!was_full) q_model.push_back(cam_pixel);
                else           ovf_new = 1'b1;
            end
            if (ovf_new) ovf_model = 1'b1;
            else if (we && w == A_STATUS && wdata[31]) ovf_model = 1'b0;
            if (we && w == A_FRAME) frame_model = wdata[15:0];
            else if (cam_sof)       frame_model = frame_model + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr      = 32'h0000_2000;
        wdata     = 32'h0;
        we        = 1'b0;
        re        = 1'b0;
        cam_valid = 1'b0;
        cam_pixel = '0;
        cam_sof   = 1'b0;
    endtask

    // Reset state: flags, counters and ready while held in reset and after.
    task automatic test_reset();
        logic [31:0] exp;
        idle_inputs();
        reset = 1'b0;
        q_model.delete();
        ovf_model   = 1'b0;
        frame_model = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cam_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b expected 1", cam_ready);
        end
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h2000_0000) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got %h expected 20000000", rdata);
        end
        reset = 1'b1;
        addr  = A_FRAME;
        #1;
        exp = exp_rdata(addr);
        n_checks++;
        if (rdata !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_frame: got %h expected %h", rdata, exp);
        end
        addr = A_DATA;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_cam_data: got %h expected 0", rdata);
        end
        step();
    endtask

    // RAM store/load and unmapped-address behaviour.
    task automatic test_ram();
        idle_inputs();
        addr = 32'h0; wdata = 32'h1111_2222; we = 1'b1; step();
        addr = 32'h10; wdata = 32'hDEAD_BEEF; we = 1'b1; step();
        addr = 32'h100; wdata = 32'hBAD0_0100; we = 1'b1; step();
        addr = 32'h2000; wdata = 32'hBAD0_2000; we = 1'b1; step();
        idle_inputs();
        addr = 32'h13;
        #1;
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("[TB] FAIL ram_load_0x10: got %h expected deadbeef", rdata);
        end
        addr = 32'h0;
        #1;
        n_checks++;
        if (rdata !== exp_rdata(addr)) begin
            n_fail++;
            $display("[TB] FAIL ram_word0_after_0x100_store: got %h expected %h", rdata, exp_rdata(addr));
        end
        addr = 32'h2000;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL unmapped_0x2000: got %h expected 0", rdata);
        end
        addr = 32'h100;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL unmapped_0x100: got %h expected 0", rdata);
        end
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h2000_0000) begin
            n_fail++;
            $display("[TB] FAIL status_after_unmapped: got %h expected 20000000", rdata);
        end
    endtask

    // Three pushes, count readback, ordered pops, then a pop on empty.
    task automatic test_fifo_basic();
        logic [31:0] exp;
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            cam_valid = 1'b1; cam_pixel = PIX_W'(i); step();
        end
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h0000_0003) begin
            n_fail++;
            $display("[TB] FAIL basic_count3: got %h expected 00000003", rdata);
        end
        addr = A_DATA; we = 1'b1; wdata = 32'hFFFF_FFFF; step();
        we = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            addr = A_DATA; re = 1'b1;
            #1;
            exp = (i <= 3) ? 32'(i) : 32'h0;
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("[TB] FAIL basic_pop%0d: got %h expected %h", i, rdata, exp);
            end
            step();
        end
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h2000_0000) begin
            n_fail++;
            $display("[TB] FAIL basic_empty_after_pops: got %h expected 20000000", rdata);
        end
    endtask

    // Fill past capacity, check full/overflow, then clear overflow.
    task automatic test_overflow();
        idle_inputs();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cam_valid = 1'b1; cam_pixel = PIX_W'(16'h0A00 + i); step();
            if (i == DEPTH - 1) begin
                n_checks++;
                if (cam_ready !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL ovf_ready_low_when_full: got %b expected 0", cam_ready);
                end
            end
        end
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'hC000_0010) begin
            n_fail++;
            $display("[TB] FAIL ovf_status_full: got %h expected c0000010", rdata);
        end
        addr = A_STATUS; we = 1'b1; wdata = 32'h8000_0000; step();
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h4000_0010) begin
            n_fail++;
            $display("[TB] FAIL ovf_cleared: got %h expected 40000010", rdata);
        end
    endtask

    // Push+pop while full drops the pixel; then sustained push+pop at half
    // full across pointer wrap, then drain and check order.
    task automatic test_full_push_pop();
        logic [31:0] exp;
        idle_inputs();
        addr = A_DATA; re = 1'b1; cam_valid = 1'b1; cam_pixel = 16'hEEEE; step();
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h8000_000F) begin
            n_fail++;
            $display("[TB] FAIL full_push_pop_status: got %h expected 8000000f", rdata);
        end
        while (q_model.size() > 8) begin
            addr = A_DATA; re = 1'b1; step();
        end
        for (int i = 0; i < 20; i++) begin
            addr = A_DATA; re = 1'b1; cam_valid = 1'b1; cam_pixel = PIX_W'($urandom);
            #1;
            exp = exp_rdata(addr);
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("[TB] FAIL wrap_pushpop_head%0d: got %h expected %h", i, rdata, exp);
            end
            step();
        end
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== exp_rdata(addr)) begin
            n_fail++;
            $display("[TB] FAIL wrap_count_unchanged: got %h expected %h", rdata, exp_rdata(addr));
        end
        for (int i = 0; i < 9; i++) begin
            addr = A_DATA; re = 1'b1;
            #1;
            exp = exp_rdata(addr);
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("[TB] FAIL wrap_drain%0d: got %h expected %h", i, rdata, exp);
            end
            step();
        end
    endtask

    // Frame counter wrap and store-over-sof priority.
    task automatic test_frame_cnt();
        idle_inputs();
        addr = A_FRAME; we = 1'b1; wdata = 32'h0000_FFFF; step();
        idle_inputs();
        cam_sof = 1'b1; step();
        idle_inputs();
        addr = A_FRAME;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL frame_wrap: got %h expected 0", rdata);
        end
        addr = A_FRAME; we = 1'b1; wdata = 32'hABCD_0005; cam_sof = 1'b1; step();
        idle_inputs();
        addr = A_FRAME;
        #1;
        n_checks++;
        if (rdata !== 32'h5) begin
            n_fail++;
            $display("[TB] FAIL frame_store_wins: got %h expected 5", rdata);
        end
        for (int i = 0; i < 3; i++) begin
            cam_sof = 1'b1; step();
        end
        idle_inputs();
        addr = A_FRAME;
        #1;
        n_checks++;
        if (rdata !== 32'h8) begin
            n_fail++;
            $display("[TB] FAIL frame_increment: got %h expected 8", rdata);
        end
    endtask

    // Randomized mix of camera traffic and CPU accesses against the model.
    task automatic test_random();
        logic [31:0] exp;
        int          sel;
        idle_inputs();
        for (int w = 8; w < 16; w++) begin
            addr = 32'(w * 4); we = 1'b1; wdata = $urandom; step();
        end
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            cam_valid = ($urandom_range(0, 99) < 55);
            cam_pixel = PIX_W'($urandom);
            cam_sof   = ($urandom_range(0, 99) < 8);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    addr = 32'(($urandom_range(8, 15) * 4) + $urandom_range(0, 3));
                2, 3, 4: addr = A_DATA | 32'($urandom_range(0, 3));
                5:       addr = A_STATUS;
                6:       addr = A_FRAME;
                7:       addr = 32'h0000_100C;
                8:       addr = 32'h0000_0100;
                default: addr = 32'h0000_2000 + ($urandom & 32'h0FFF_FFFC);
            endcase
            if ($urandom_range(0, 99) < 20) begin
                we = 1'b1; wdata = $urandom;
            end else begin
                re = ($urandom_range(0, 99) < 70);
            end
            #1;
            exp = exp_rdata(addr);
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("[TB] FAIL rand_rdata%0d: addr %h got %h expected %h", i, addr, rdata, exp);
            end
            if (cam_ready !== (q_model.size() != DEPTH)) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL rand_ready%0d: got %b expected %b", i, cam_ready, q_model.size() != DEPTH);
            end else begin
                n_checks++;
            end
            step();
        end
    endtask

    // Async reset in the middle of traffic with count=7 and overflow set.
    task automatic test_mid_reset();
        idle_inputs();
        while (q_model.size() < DEPTH) begin
            cam_valid = 1'b1; cam_pixel = PIX_W'($urandom); step();
        end
        cam_valid = 1'b1; step();
        idle_inputs();
        while (q_model.size() > 7) begin
            addr = A_DATA; re = 1'b1; step();
        end
        idle_inputs();
        addr = A_FRAME; we = 1'b1; wdata = 32'h0000_1234; step();
        idle_inputs();
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h8000_0007) begin
            n_fail++;
            $display("[TB] FAIL midrst_pre_status: got %h expected 80000007", rdata);
        end
        reset = 1'b0;
        q_model.delete();
        ovf_model   = 1'b0;
        frame_model = 16'h0;
        #1;
        n_checks++;
        if (rdata !== 32'h2000_0000) begin
            n_fail++;
            $display("[TB] FAIL midrst_status: got %h expected 20000000", rdata);
        end
        n_checks++;
        if (cam_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_ready: got %b expected 1", cam_ready);
        end
        addr = A_FRAME;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midrst_frame: got %h expected 0", rdata);
        end
        addr = 32'h10; we = 1'b1; wdata = 32'h0BAD_F00D; cam_valid = 1'b1; cam_sof = 1'b1;
        step();
        idle_inputs();
        reset = 1'b1;
        addr  = 32'h10;
        #1;
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("[TB] FAIL midrst_ram_kept: got %h expected deadbeef", rdata);
        end
        addr = A_STATUS;
        #1;
        n_checks++;
        if (rdata !== 32'h2000_0000) begin
            n_fail++;
            $display("[TB] FAIL midrst_ignored_while_low: got %h expected 20000000", rdata);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ram();
        test_fifo_basic();
        test_overflow();
        test_full_push_pop();
        test_frame_cnt();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
